pwm_capture: RTL and testbench
==============================

Name: pwm_capture

Overview:
- Receive-side counterpart of the team's PWM generator.
- Samples an external PWM waveform and measures its period and high time in clk cycles.
- Converts the measurement to a DUTY_CYCLE_WIDTH-bit duty code on the same scale the generator's duty_cycle input uses.
- Used for loopback checking of the generator and for reading external PWM sources, such as fan tach or servo feedback.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- PWM_FREQ, 20000, nominal input PWM frequency in Hz. Used only for the timeout.
- DUTY_CYCLE_WIDTH, 8, width of the duty code.
- CNT_WIDTH, 16, width of the period/high counters. Must hold TIMEOUT_CYCLES.
- TIMEOUT_CYCLES, 4*CLK_FREQ/PWM_FREQ (10000), edge-free cycles before a stuck level is declared.
- FILTER_LEN, 4, glitch filter length. Used only with PWM_CAPTURE_FILTER_EN.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- pwm_in  in  1  asynchronous PWM input.
- period  out  CNT_WIDTH  last measured period in clk cycles.
- high_time  out  CNT_WIDTH  last measured high time in clk cycles.
- duty_cycle  out  DUTY_CYCLE_WIDTH  last duty code.
- valid  out  1  one-cycle pulse when period/high_time/duty_cycle update.
- stuck  out  1  high while input has had no edge for TIMEOUT_CYCLES.
- overrun  out  1  sticky; a measurement was dropped because the divider was busy.

Behaviour:
- Reset (rst=1 at a clk edge) forces all outputs, counters, synchronizer and FSM to 0/IDLE.
  - Reset mid-measurement or mid-divide discards all partial work.
- Input path:
  - 2-flop synchronizer, then a registered copy for edge detect.
  - rise = s & ~s_d; fall = ~s & s_d.
  - Edge-to-detect latency is 3 cycles.
- Counters:
  - per_cnt increments every cycle and saturates at all-ones.
  - hi_cnt increments while the synced input is 1 and saturates.
  - Both clear to 1 on rise; the rise cycle itself counts as 1.
  - On fall, hi_cnt is latched to hi_lat.
- FSM states:
  - IDLE: wait for the first rise. Counters clear on it, then go to ARMED. No measurement is produced from the partial first period.
  - ARMED: on the next rise, snapshot P=per_cnt and H=hi_lat, then go to DIVIDE. If P==0, do not divide (defensive).
  - DIVIDE: restoring divide computing Q = floor(H * 2^DUTY_CYCLE_WIDTH / P).
    - Takes exactly DUTY_CYCLE_WIDTH cycles, one quotient bit per cycle, MSB first.
    - Saturate Q to 2^DUTY_CYCLE_WIDTH-1 if H>=P.
    - Then go to DONE.
  - DONE: one cycle. Register period=P, high_time=H, duty_cycle=Q; assert valid=1; return to ARMED.
    - Latency from the detected rise to valid is DUTY_CYCLE_WIDTH+2 cycles.
- Counters keep running during DIVIDE/DONE. A rise during DIVIDE/DONE still restarts the counters, but its snapshot is dropped and overrun is set.
  - overrun clears only on rst.
- Timeout:
  - A timeout counter clears on any rise/fall.
  - When it reaches TIMEOUT_CYCLES:
    - stuck=1.
    - period=0, high_time=0.
    - duty_cycle = all-ones if the synced input is 1, else 0.
    - valid pulses once.
    - FSM goes to IDLE.
  - stuck stays 1 until the next edge. On that edge, stuck=0 and the FSM re-arms as from IDLE.
  - A timeout in DIVIDE aborts the divide; the timeout result wins.
- Width rule: H and P saturate at 2^CNT_WIDTH-1. Dividend width is CNT_WIDTH+DUTY_CYCLE_WIDTH.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- When defined: insert a debounce after the synchronizer.
  - The filtered level changes only after the synced input holds the new value for FILTER_LEN consecutive cycles.
  - Pulses shorter than FILTER_LEN are ignored.
  - Edge-to-detect latency becomes 3+FILTER_LEN cycles.
  - Measured period is unchanged; high_time is unchanged for clean inputs.
- When undefined: no filter logic; the synced signal drives edge detect directly.

Test Plan:
- PWM period 2500 cycles, high 625, 4 periods → first valid after the 2nd rise + 10 cycles; period=2500, high_time=625, duty_cycle=64 each valid; overrun=0.
- Loopback from the generator at duty_cycle=8'h0F → period=2500, duty_cycle within ±1 of 15.
- pwm_in held 0 for 12000 cycles after activity → at the 10000th edge-free cycle, stuck=1, duty_cycle=0, period=0, one valid. Held 1 instead → duty_cycle=255. The next edge clears stuck.
- Period 2500, high 2499 → duty_cycle=255 (no overflow). Then period 8 (edges every 4) → overrun=1, and no valid for dropped snapshots.
- rst pulsed for 1 cycle mid-DIVIDE → all outputs 0 the next cycle, no valid. The first valid arrives only after two new rises.
- With PWM_CAPTURE_FILTER_EN, FILTER_LEN=4: 2-cycle high glitch inside the low phase → measurement unchanged (period=2500, high_time=625). Without the macro, the same glitch produces a short period and a changed duty.

Source files
------------

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an external PWM and derives a duty code.
// Optional debounce after the synchronizer: define PWM_CAPTURE_FILTER_EN.

module pwm_capture #(
  parameter int CLK_FREQ         = 50000000,
  parameter int PWM_FREQ         = 20000,
  parameter int DUTY_CYCLE_WIDTH = 8,
  parameter int CNT_WIDTH        = 16,
  parameter int TIMEOUT_CYCLES   = 4 * CLK_FREQ / PWM_FREQ,
  parameter int FILTER_LEN       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        pwm_in,
  output logic [CNT_WIDTH-1:0]        period,
  output logic [CNT_WIDTH-1:0]        high_time,
  output logic [DUTY_CYCLE_WIDTH-1:0] duty_cycle,
  output logic                        valid,
  output logic                        stuck,
  output logic                        overrun
);

  localparam int W  = DUTY_CYCLE_WIDTH;
  localparam int CW = CNT_WIDTH;
  localparam int BW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    DIVIDE,
    DONE
  } state_t;

  logic s1, s2, s, s_d;
  logic rise, fall, edge_any;

  // two-flop synchronizer for the asynchronous input
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= pwm_in;
      s2 <= s1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  logic          filt;
  logic [FW-1:0] fcnt;

  // level follows s2 only after FILTER_LEN consecutive differing cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= 1'b0;
      fcnt <= '0;
    end else if (s2 == filt) begin
      fcnt <= '0;
    end else if (fcnt == FW'(FILTER_LEN - 1)) begin
      filt <= s2;
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + FW'(1);
    end
  end

  assign s = filt;
`else
  assign s = s2;
`endif

  // delayed copy of the level for edge detection
  always_ff @(posedge clk) begin
    if (rst) s_d <= 1'b0;
    else     s_d <= s;
  end

  assign rise     = s & ~s_d;
  assign fall     = ~s & s_d;
  assign edge_any = rise | fall;

  logic [CW-1:0] per_cnt, hi_cnt, hi_lat;

  // free-running period/high counters, restarted at every rise
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
      hi_lat  <= '0;
    end else begin
      if (rise) begin
        per_cnt <= CW'(1);
        hi_cnt  <= CW'(1);
      end else begin
        if (per_cnt != '1)      per_cnt <= per_cnt + CW'(1);
        if (s && hi_cnt != '1)  hi_cnt  <= hi_cnt + CW'(1);
      end
      if (fall) hi_lat <= hi_cnt;
    end
  end

  logic [CW-1:0] to_cnt;
  logic          to_hit;

  assign to_hit = ~edge_any & ~stuck &
                  (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  // counts edge-free cycles; parks once stuck is flagged
  always_ff @(posedge clk) begin
    if (rst)           to_cnt <= '0;
    else if (edge_any) to_cnt <= '0;
    else if (!stuck)   to_cnt <= to_cnt + CW'(1);
  end

  state_t state_q, state_d;
  logic   snap, div_en, fin, drop;

  logic [CW-1:0] p_q, h_q, rem_q;
  logic [W-1:0]  q_q;
  logic [BW-1:0] bcnt_q;
  logic          sat_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and datapath strobes; a timeout overrides everything
  always_comb begin
    state_d = state_q;
    snap    = 1'b0;
    div_en  = 1'b0;
    fin     = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rise) state_d = ARMED;
      end
      ARMED: begin
        if (rise && per_cnt != '0) begin
          snap    = 1'b1;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        div_en = 1'b1;
        drop   = rise;
        if (bcnt_q == BW'(W - 1)) state_d = DONE;
      end
      DONE: begin
        fin     = 1'b1;
        drop    = rise;
        state_d = ARMED;
      end
      default: state_d = IDLE;
    endcase
    if (to_hit) begin
      state_d = IDLE;
      snap    = 1'b0;
      div_en  = 1'b0;
      fin     = 1'b0;
    end
  end

  logic [CW:0] rem_sh, rem_sub;
  logic        ge;

  assign rem_sh  = {rem_q, 1'b0};
  assign ge      = rem_sh >= {1'b0, p_q};
  assign rem_sub = rem_sh - {1'b0, p_q};

  // restoring divider: H*2^W / P, one quotient bit per cycle, MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      p_q    <= '0;
      h_q    <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      bcnt_q <= '0;
      sat_q  <= 1'b0;
    end else if (snap) begin
      p_q    <= per_cnt;
      h_q    <= hi_lat;
      rem_q  <= hi_lat;
      q_q    <= '0;
      bcnt_q <= '0;
      sat_q  <= hi_lat >= per_cnt;
    end else if (div_en) begin
      rem_q  <= ge ? rem_sub[CW-1:0] : rem_sh[CW-1:0];
      q_q    <= {q_q[W-2:0], ge};
      bcnt_q <= bcnt_q + BW'(1);
    end
  end

  // result registers, valid pulse, stuck and sticky overrun
  always_ff @(posedge clk) begin
    if (rst) begin
      period     <= '0;
      high_time  <= '0;
      duty_cycle <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (drop) overrun <= 1'b1;
      if (to_hit) begin
        stuck      <= 1'b1;
        period     <= '0;
        high_time  <= '0;
        duty_cycle <= s ? '1 : '0;
        valid      <= 1'b1;
      end else begin
        if (edge_any) stuck <= 1'b0;
        if (fin) begin
          period     <= p_q;
          high_time  <= h_q;
          duty_cycle <= sat_q ? '1 : q_q;
          valid      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized PWM stimulus, edge-level reference model,
// scoreboard queue checked by an independent valid monitor.

module tb_pwm_capture;

  localparam int W  = 8;
  localparam int CW = 16;
  localparam int TO = 10000;

`ifdef PWM_CAPTURE_FILTER_EN
  localparam bit G = 1'b0;
`else
  localparam bit G = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          pwm_in;
  logic [CW-1:0] period, high_time;
  logic [W-1:0]  duty_cycle;
  logic          valid, stuck, overrun;

  always #5 clk = ~clk;

  pwm_capture #(
    .CLK_FREQ(50000000),
    .PWM_FREQ(20000),
    .DUTY_CYCLE_WIDTH(W),
    .CNT_WIDTH(CW),
    .TIMEOUT_CYCLES(TO),
    .FILTER_LEN(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pwm_in(pwm_in),
    .period(period),
    .high_time(high_time),
    .duty_cycle(duty_cycle),
    .valid(valid),
    .stuck(stuck),
    .overrun(overrun)
  );

  typedef struct {
    longint per;
    longint hi;
    longint duty;
    bit     stk;
  } exp_t;

  exp_t   sbq[$];
  exp_t   e;
  int     checks = 0;
  int     errors = 0;

  longint tnow      = 0;
  longint last_rise = 0;
  longint last_acc  = -1000000;
  longint high_lat  = 0;
  bit     armed     = 1'b0;
  bit     exp_ovr   = 1'b0;

  function automatic exp_t mk(longint p, longint h, longint d, bit k);
    exp_t x;
    x.per  = p;
    x.hi   = h;
    x.duty = d;
    x.stk  = k;
    return x;
  endfunction

  // reference: measurement between consecutive input rises, dropped
  // when it lands inside the divide/done window of the previous one
  function automatic void m_edge(bit lvl);
    longint p, h, d;
    if (lvl) begin
      if (!armed) begin
        armed    = 1'b1;
        last_acc = -1000000;
      end else if (tnow - last_acc <= W + 1) begin
        exp_ovr = 1'b1;
      end else begin
        p = tnow - last_rise;
        if (p > 65535) p = 65535;
        h = high_lat;
        if (h >= p) d = 255;
        else        d = (h * 256) / p;
        sbq.push_back(mk(p, h, d, 1'b0));
        last_acc = tnow;
      end
      last_rise = tnow;
    end else begin
      high_lat = tnow - last_rise;
      if (high_lat > 65535) high_lat = 65535;
    end
  endfunction

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic seg(input bit lvl, input int len, input bit mdl);
    if (mdl && (lvl != pwm_in)) m_edge(lvl);
    pwm_in = lvl;
    if (len > TO) begin
      sbq.push_back(mk(0, 0, lvl ? 255 : 0, 1'b1));
      armed = 1'b0;
    end
    repeat (len) @(negedge clk);
    tnow += len;
  endtask

  task automatic pwm(input int per, input int hi, input int n);
    for (int i = 0; i < n; i++) begin
      seg(1'b1, hi, 1'b1);
      seg(1'b0, per - hi, 1'b1);
    end
  endtask

  // monitor: every valid must match the oldest expected measurement
  always @(negedge clk) begin
    if (valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid: period=%0d high=%0d duty=%0d stuck=%0d",
                 period, high_time, duty_cycle, stuck);
      end else begin
        e = sbq.pop_front();
        if (period != e.per || high_time != e.hi ||
            duty_cycle != e.duty || stuck != e.stk) begin
          errors++;
          $display("FAIL measurement: got p=%0d h=%0d d=%0d s=%0d, expected p=%0d h=%0d d=%0d s=%0d",
                   period, high_time, duty_cycle, stuck,
                   e.per, e.hi, e.duty, e.stk);
        end
      end
    end
  end

  initial begin
    int per, hi;
    pwm_in = 1'b0;
    rst    = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_valid", valid, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;

    seg(1'b0, 100, 1'b1);
    pwm(2500, 625, 4);
    chk("overrun_clean", overrun, exp_ovr);
    pwm(2500, 147, 2);

    for (int i = 0; i < 8; i++) begin
      per = $urandom_range(1500, 12);
      hi  = $urandom_range(per - 1, 1);
      pwm(per, hi, 1);
    end

    pwm(2500, 2499, 2);
    pwm(8, 4, 8);
    seg(1'b1, 100, 1'b1);
    chk("overrun_set", overrun, exp_ovr);

    seg(1'b0, 12000, 1'b1);
    chk("stuck_lo", stuck, 1);
    chk("stuck_lo_duty", duty_cycle, 0);
    chk("stuck_lo_period", period, 0);
    chk("stuck_lo_high", high_time, 0);
    seg(1'b1, 12000, 1'b1);
    chk("stuck_hi", stuck, 1);
    chk("stuck_hi_duty", duty_cycle, 255);
    seg(1'b0, 10, 1'b1);
    chk("stuck_clear", stuck, 0);
    seg(1'b0, 1000, 1'b1);

    pwm(2500, 625, 1);
    seg(1'b1, 625, 1'b1);
    seg(1'b0, 375, 1'b1);
    seg(1'b1, 2, G);
    seg(1'b0, 1498, G);
    pwm(2500, 625, 2);

    seg(1'b1, 3, 1'b1);
    seg(1'b0, 4, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    tnow += 1;
    sbq.delete();
    armed   = 1'b0;
    exp_ovr = 1'b0;
    chk("mid_rst_period", period, 0);
    chk("mid_rst_high", high_time, 0);
    chk("mid_rst_duty", duty_cycle, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_overrun", overrun, exp_ovr);

    seg(1'b0, 200, 1'b1);
    pwm(2500, 625, 3);
    seg(1'b1, 625, 1'b1);
    seg(1'b0, 200, 1'b1);

    for (int i = 0; i < 200; i++) begin
      if (sbq.size() == 0) break;
      @(negedge clk);
    end
    chk("drain_pending", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
